frame_buf_ctrl: RTL
===================

# frame_buf_ctrl

Ping-pong sequencer for the frame buffer's `data_mem` instance. The memory is split into two banks: a producer stream fills one bank while a consumer stream drains the other, and the banks swap at frame boundaries. The block drives the `data_mem` write and read ports directly and presents valid/ready handshakes on both stream sides.

## Interface
- `DATA_WIDTH`, 32, word width; matches `data_mem`.
- `ADDR_WIDTH`, 3, `data_mem` address width. The MSB selects the bank, so `DEPTH = 2^(ADDR_WIDTH-1)` words per frame. Legal range is ≥ 2.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `in_valid`  in  1  producer word valid.
- `in_data`  in  DATA_WIDTH  producer word.
- `in_ready`  out  1  controller accepts a word.
- `out_valid`  out  1  consumer word valid.
- `out_data`  out  DATA_WIDTH  consumer word.
- `out_last`  out  1  qualifies the final word of a frame.
- `out_ready`  in  1  consumer accepts a word.
- `mem_wr_en`  out  1  to `data_mem.wr_en`.
- `mem_wr_addr`  out  ADDR_WIDTH  to `data_mem.wr_addr`.
- `mem_wr_data`  out  DATA_WIDTH  to `data_mem.wr_data`.
- `mem_rd_en`  out  1  to `data_mem.rd_en`.
- `mem_rd_addr`  out  ADDR_WIDTH  to `data_mem.rd_addr`.
- `mem_rd_data`  in  DATA_WIDTH  from `data_mem.rd_data`; valid the cycle after `mem_rd_en`.
- `wr_bank`, `rd_bank`  out  1 each  current bank for the writer and the reader (status).

## Operation
**State**
- `full[1:0]` flags.
- Writer bank `wb` and write offset `wa`.
- Reader bank `rb` and read offset `ra`.
- Reader FSM: `R_IDLE`, `R_DRAIN`.
- 2-entry output FIFO with a read-in-flight bit.

**Writer**
- `in_ready = reset_n && !full[wb]`.
- `mem_wr_en = in_valid && in_ready`.
- `mem_wr_addr = {wb, wa}` and `mem_wr_data = in_data`.
- On each accepted word, `wa` increments.
- When `wa == DEPTH-1` is accepted: set `full[wb]`, toggle `wb`, and wrap `wa` to 0.

**Reader FSM**
- In `R_IDLE`: when `full[rb]` is set, go to `R_DRAIN` with `ra = 0`.
- In `R_DRAIN`: issue a read (`mem_rd_en = 1`, `mem_rd_addr = {rb, ra}`) when `occupancy + in_flight − pop < 2`, where `pop = out_valid && out_ready`.
- On issuing `ra == DEPTH-1`: the bank is released per Configuration, `ra` wraps to 0, and the tag `last` travels with that word into the FIFO.
- `rb` toggles on release.
- After release the FSM goes to `R_IDLE`, or stays in `R_DRAIN` if `full[rb]` is already set.

**Output**
- `out_data`/`out_last` come from the FIFO head.
- `out_valid` is high when the FIFO is non-empty.

**Bank safety**
- The writer never touches a full bank; the reader only reads a full bank. Set and clear therefore never hit the same flag in the same cycle.
- A freed bank's address 0 was read at least `DEPTH` cycles earlier.

**Reset (async, mid-operation included)**
- `full = 0`, `wb = rb = 0`, `wa = ra = 0`, FSM `R_IDLE`, FIFO empty, in-flight cleared.
- Outputs during and after reset: `in_ready = 0` while reset is low, 1 after; `out_valid = 0`, `out_last = 0`, `mem_wr_en = 0`, `mem_rd_en = 0`, `wr_bank = rd_bank = 0`.
- `mem_rd_data` returning after reset is discarded.
- Partially written or read frames are abandoned.

## Timing
- Write: a word accepted in cycle N is in memory after the N→N+1 edge.
- Frame latency: last producer word accepted in cycle N → `full` set at N+1 → first read issued in N+1 → `out_valid` high in cycle N+3.
- Throughput: one word per cycle on each side, concurrently, when not blocked.
- Read pipeline with `out_ready` held high: no bubbles within a frame or across back-to-back full banks.
- `out_valid`, `out_data` and `out_last` hold stable while `out_ready` is low.
- `in_ready` may drop only in the cycle after the last word of a frame is accepted into a bank whose partner is still full.

## Configuration
- Macro `FRAME_BUF_REPEAT_EN`.
- **Defined:** at the last read of a frame, if `full[~rb]` is set, clear `full[rb]` and toggle `rb`. Otherwise keep `full[rb]` set and re-read the same bank from `ra = 0`. The consumer never starves once the first frame exists; the writer is blocked only while its bank is full.
- **Undefined:** always clear `full[rb]` and toggle `rb` at the last read. The reader idles (`out_valid = 0`) until the next frame completes.

## Test plan
Directed scenarios, all with `ADDR_WIDTH = 3` (`DEPTH = 4`) and reset pulsed at start:
1. **Basic frame.** Write 0x10..0x13 with `out_ready = 1`. Required: `mem_wr_addr` 0..3, then `mem_rd_addr` 0..3; `out_data` 0x10..0x13 with `out_last` on 0x13; first `out_valid` 3 cycles after the 4th accept.
2. **Back-to-back frames.** Stream 0x20..0x27 continuously. Required: bank 1 written at addresses 4..7 while bank 0 is read; output 0x20..0x27 gap-free, `out_last` on 0x23 and 0x27.
3. **Backpressure.** Hold `out_ready = 0` after the first frame and write 8 more words. Required: `in_ready` drops after word 4 (both banks full); the held `out_data` stays 0x10; releasing `out_ready` drains in order.
4. **Repeat.** With the macro defined, write a single frame 0xA0..0xA3 with `out_ready = 1`. Required: output repeats 0xA0..0xA3 until the next frame completes. Undefined: exactly one frame, then `out_valid = 0`.
5. **Reset mid-frame.** Assert reset after 2 words written and 1 word output. Required: all outputs return to reset values asynchronously; a subsequent frame 0x30..0x33 is written at addresses 0..3 and read back correctly.

Source files
------------

// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: ping-pong bank sequencer for data_mem with valid/ready streams on both sides.
// Optional macro FRAME_BUF_REPEAT_EN: keep replaying the newest complete frame until another one exists.
module frame_buf_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  wr_bank,
  output logic                  rd_bank
);
  localparam int OW = ADDR_WIDTH - 1;
  localparam logic [OW-1:0] LAST_OFS = '1;

  typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [1:0]    full;
  logic          wb, rb;
  logic [OW-1:0] wa, ra;
  r_state_t      r_state;
  logic          in_flight, in_flight_last;
  logic [1:0]    occ;
  entry_t        head, tail, fresh;

  logic       wr_fire, wr_done, pop;
  logic       rd_active, rd_issue, rd_last, rd_release;
  logic [2:0] level;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    in_ready  = reset && !full[wb];
    wr_fire   = in_valid && in_ready;
    wr_done   = wr_fire && (wa == LAST_OFS);
    out_valid = (occ != 2'd0);
    pop       = out_valid && out_ready;
    level     = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
    // Issuing straight out of R_IDLE saves a cycle of frame latency.
    rd_active = (r_state == R_DRAIN) || full[rb];
    rd_issue  = rd_active && (level < 3'd2);
    rd_last   = rd_issue && (ra == LAST_OFS);
`ifdef FRAME_BUF_REPEAT_EN
    rd_release = rd_last && full[~rb];
`else
    rd_release = rd_last;
`endif
    fresh = '{last: in_flight_last, data: mem_rd_data};
  end

  assign mem_wr_en   = wr_fire;
  assign mem_wr_addr = {wb, wa};
  assign mem_wr_data = in_data;
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = {rb, ra};
  assign out_data    = head.data;
  assign out_last    = out_valid && head.last;
  assign wr_bank     = wb;
  assign rd_bank     = rb;

  // NOTE: sequential state uses non-blocking assignments so each register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full           <= '0;
      wb             <= 1'b0;
      wa             <= '0;
      rb             <= 1'b0;
      ra             <= '0;
      r_state        <= R_IDLE;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      if (wr_fire) wa <= wa + 1'b1;
      if (wr_done) begin
        full[wb] <= 1'b1;
        wb       <= ~wb;
      end
      // The writer never owns a full bank, so this clear never collides with the set above.
      if (rd_release) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
      if (rd_issue) ra <= ra + 1'b1;
      in_flight      <= rd_issue;
      in_flight_last <= rd_last;
      if (rd_release) r_state <= full[~rb] ? R_DRAIN : R_IDLE;
      else if (full[rb]) r_state <= R_DRAIN;
    end
  end

  // NOTE: the two FIFO slots are ordinary registers and are reset too; data_mem itself is never cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({in_flight, pop})
        2'b10: begin
          if (occ == 2'd0) head <= fresh;
          else             tail <= fresh;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) head <= fresh;
          else begin
            head <= tail;
            tail <= fresh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
